mips_pipeline: RTL and testbench
================================

MIPS_PIPELINE -- requirements
Module: mips_pipeline

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; low clears all state, high runs.
REQ-004 Port: result  output  32  write-back data of the instruction currently in WB; 0 when WB holds no register write.
REQ-005 Port: halt  output  1  sticky; high once a HALT instruction reaches WB.
REQ-006 Parameter: IMEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-007 Parameter: DMEM_WORDS, default 256, data memory depth in 32-bit words.

Function
REQ-008 SHALL be a 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
REQ-009 Instruction memory SHALL be an internal word array, indexed by PC[31:2] modulo IMEM_WORDS, preloadable by hierarchical $readmemh, and zero-initialised; the instruction word 0 is NOP.
REQ-010 Register file SHALL be 32x32; $0 reads 0 and ignores writes; a WB write is visible to an ID read in the same cycle (write-through).
REQ-011 Supported: R-type ADD, SUB, AND, OR, SLT, JR (funct 0x08), JALR (funct 0x09); I-type ADDI (0x08), LW (0x23), SW (0x2B), BEQ (0x04), BNE (0x05); J (0x02), JAL (0x03); HALT is opcode 0x3F.
REQ-012 Unsupported opcodes SHALL execute as NOP.
REQ-013 ADDI immediate SHALL be sign-extended; arithmetic SHALL wrap modulo 2^32 with no overflow trap; SLT SHALL use a signed compare.
REQ-014 Branch/jump target and condition SHALL resolve in ID: BEQ/BNE to PC+4+(sext(imm)<<2); J/JAL to {PC+4[31:28], target, 2'b00}; JR/JALR to rs.
REQ-015 There SHALL be no delay slot; a taken branch or any jump SHALL flush the single instruction in IF (it becomes NOP); 1-cycle penalty.
REQ-016 JAL SHALL write PC+4 to $31; JALR SHALL write PC+4 to rd (rd=0 means no write).
REQ-017 EX operands SHALL be forwarded from EX/MEM and MEM/WB, with EX/MEM taking priority; rs/rt of ID branch/jump compares SHALL be forwarded from EX/MEM and MEM/WB.
REQ-018 Load-use hazard (LW in EX, dependent instruction in ID) SHALL stall PC and IF/ID for 1 cycle and insert a bubble into EX.
REQ-019 A branch or JR/JALR in ID that depends on an ALU result in EX SHALL stall 1 cycle; if it depends on an LW in EX, it SHALL stall 2 cycles.
REQ-020 Data memory SHALL be word-addressed by ALU result [31:2] modulo DMEM_WORDS; LW reads combinationally in MEM; SW writes on the clock edge.
REQ-021 HALT SHALL stop PC and fetch once decoded; instructions older than HALT SHALL complete; younger instructions SHALL be flushed; halt SHALL rise in the cycle HALT occupies WB and stay high until reset.
REQ-022 PC SHALL wrap naturally modulo 2^32; instruction fetch wraps modulo IMEM_WORDS.

Reset
REQ-023 While reset is low: PC=0, all pipeline registers hold NOP with control signals 0, all 32 registers are 0, data memory is 0, result=0, halt=0.
REQ-024 Reset asserted mid-operation SHALL take effect immediately (asynchronously); after deassertion, fetch SHALL restart at address 0 on the next rising edge.
REQ-025 Instruction memory contents SHALL NOT be cleared by reset.

Verification
REQ-026 addi $1,$0,5; addi $2,$0,100; addi $16,$0,24; jr $16; addi $3,$0,3; addi $4,$0,4; (addr 24) addi $5,$2,53; addi $6,$1,1; halt -> $5=153, $6=6, $3=0, $4=0, halt=1.
REQ-027 addi $7,$0,64; jalr $7; addi $8,$0,8; addi $9,$0,9; addi $10,$0,10 placed before 64; (addr 64) addi $11,$0,11; halt -> $11=11, $8=$9=$10=0, $31 = address of jalr + 4.
REQ-028 addi $1,$0,7; sw $1,4($0); lw $2,4($0); add $3,$2,$2 -> load-use stall of 1 cycle; $3=14.
REQ-029 addi $1,$0,1; beq $1,$1,+1; addi $2,$0,9; addi $3,$0,3; halt -> $2=0, $3=3; with bne instead, $2=9.
REQ-030 jal to a HALT at word 10 from word 2 -> $31=12, halt=1; hold reset low mid-run -> PC=0, all registers 0, halt=0.

Source files
------------

// File: rtl/mips_pipeline.sv
// mips_pipeline: 5-stage in-order MIPS subset (IF/ID/EX/MEM/WB) with forwarding,
// ID-stage branch/jump resolution without delay slot, and a sticky HALT.
module mips_pipeline #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] result,
    output logic        halt
);
    localparam int IW = IMEM_WORDS > 1 ? $clog2(IMEM_WORDS) : 1;
    localparam int DW = DMEM_WORDS > 1 ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] r_imem [IMEM_WORDS];
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] r_rf [32];

    logic [31:0] r_pc, r_ifid_inst, r_ifid_pc4;
    logic        r_stop, r_halt;
    logic [31:0] r_ex_a, r_ex_b, r_ex_imm, r_ex_pc4;
    logic [4:0]  r_ex_rs, r_ex_rt, r_ex_dst;
    logic [2:0]  r_ex_aop;
    logic        r_ex_wr, r_ex_mrd, r_ex_mwr, r_ex_imm_en, r_ex_link, r_ex_halt;
    logic [31:0] r_mem_res, r_mem_sd;
    logic [4:0]  r_mem_dst;
    logic        r_mem_wr, r_mem_mrd, r_mem_mwr, r_mem_halt;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_dst;
    logic        r_wb_wr, r_wb_halt;

    logic [IW-1:0] w_iidx;
    logic [DW-1:0] w_didx;
    logic [5:0]    w_op, w_fn;
    logic [4:0]    w_rs, w_rt, w_rd, w_dst;
    logic [2:0]    w_aop;
    logic [31:0]   w_imm, w_rs_v, w_rt_v, w_tgt, w_pc4;
    logic [31:0]   w_fa, w_fb, w_alu_b, w_alu, w_ex_res, w_ld;
    logic          w_alu_r, w_jr, w_jalr, w_addi, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_hlt;
    logic          w_use_rs, w_use_rt, w_wr, w_br, w_take, w_dex, w_dmem, w_stall;

    assign w_iidx = IW'(r_pc[31:2] % 30'(IMEM_WORDS));
    assign w_didx = DW'(r_mem_res[31:2] % 30'(DMEM_WORDS));
    assign w_pc4  = r_pc + 32'd4;

    assign w_op   = r_ifid_inst[31:26];
    assign w_rs   = r_ifid_inst[25:21];
    assign w_rt   = r_ifid_inst[20:16];
    assign w_rd   = r_ifid_inst[15:11];
    assign w_fn   = r_ifid_inst[5:0];
    assign w_imm  = {{16{r_ifid_inst[15]}}, r_ifid_inst[15:0]};

    assign w_alu_r = w_op == 6'h00 && (w_fn == 6'h20 || w_fn == 6'h22 || w_fn == 6'h24 ||
                                       w_fn == 6'h25 || w_fn == 6'h2A);
    assign w_jr    = w_op == 6'h00 && w_fn == 6'h08;
    assign w_jalr  = w_op == 6'h00 && w_fn == 6'h09;
    assign w_addi  = w_op == 6'h08;
    assign w_lw    = w_op == 6'h23;
    assign w_sw    = w_op == 6'h2B;
    assign w_beq   = w_op == 6'h04;
    assign w_bne   = w_op == 6'h05;
    assign w_j     = w_op == 6'h02;
    assign w_jal   = w_op == 6'h03;
    assign w_hlt   = w_op == 6'h3F;

    assign w_use_rs = w_alu_r || w_jr || w_jalr || w_addi || w_lw || w_sw || w_beq || w_bne;
    assign w_use_rt = w_alu_r || w_sw || w_beq || w_bne;
    assign w_br     = w_beq || w_bne || w_jr || w_jalr;
    assign w_dst    = (w_alu_r || w_jalr) ? w_rd : w_jal ? 5'd31 : w_rt;
    assign w_wr     = (w_alu_r || w_jalr || w_jal || w_addi || w_lw) && w_dst != 5'd0;
    assign w_aop    = !w_alu_r ? 3'd0 : w_fn == 6'h22 ? 3'd1 : w_fn == 6'h24 ? 3'd2 :
                      w_fn == 6'h25 ? 3'd3 : w_fn == 6'h2A ? 3'd4 : 3'd0;

    // ID operands: EX/MEM forward, then write-through of the WB write, then the register file
    assign w_rs_v = (r_mem_wr && r_mem_dst == w_rs) ? r_mem_res :
                    (r_wb_wr && r_wb_dst == w_rs) ? r_wb_data : r_rf[w_rs];
    assign w_rt_v = (r_mem_wr && r_mem_dst == w_rt) ? r_mem_res :
                    (r_wb_wr && r_wb_dst == w_rt) ? r_wb_data : r_rf[w_rt];

    assign w_dex   = (w_use_rs && w_rs == r_ex_dst) || (w_use_rt && w_rt == r_ex_dst);
    assign w_dmem  = (w_use_rs && w_rs == r_mem_dst) || (w_use_rt && w_rt == r_mem_dst);
    assign w_stall = (r_ex_wr && w_dex && (r_ex_mrd || w_br)) ||
                     (w_br && r_mem_wr && r_mem_mrd && w_dmem);

    assign w_take = (w_beq && w_rs_v == w_rt_v) || (w_bne && w_rs_v != w_rt_v) ||
                    w_j || w_jal || w_jr || w_jalr;
    assign w_tgt  = (w_jr || w_jalr) ? w_rs_v :
                    (w_j || w_jal) ? {r_ifid_pc4[31:28], r_ifid_inst[25:0], 2'b00} :
                    r_ifid_pc4 + {w_imm[29:0], 2'b00};

    assign w_fa     = (r_mem_wr && r_mem_dst == r_ex_rs) ? r_mem_res :
                      (r_wb_wr && r_wb_dst == r_ex_rs) ? r_wb_data : r_ex_a;
    assign w_fb     = (r_mem_wr && r_mem_dst == r_ex_rt) ? r_mem_res :
                      (r_wb_wr && r_wb_dst == r_ex_rt) ? r_wb_data : r_ex_b;
    assign w_alu_b  = r_ex_imm_en ? r_ex_imm : w_fb;
    assign w_alu    = r_ex_aop == 3'd1 ? w_fa - w_alu_b :
                      r_ex_aop == 3'd2 ? w_fa & w_alu_b :
                      r_ex_aop == 3'd3 ? w_fa | w_alu_b :
                      r_ex_aop == 3'd4 ? {31'd0, $signed(w_fa) < $signed(w_alu_b)} :
                      w_fa + w_alu_b;
    assign w_ex_res = r_ex_link ? r_ex_pc4 : w_alu;
    assign w_ld     = r_dmem[w_didx];

    assign result = r_wb_wr ? r_wb_data : 32'd0;
    assign halt   = r_halt | r_wb_halt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= '0;
            r_ifid_inst <= '0;
            r_ifid_pc4  <= '0;
            r_stop      <= 1'b0;
        end else if (!w_stall) begin
            if (r_stop || w_hlt) begin
                r_stop      <= 1'b1;
                r_ifid_inst <= '0;
            end else if (w_take) begin
                r_pc        <= w_tgt;
                r_ifid_inst <= '0;
            end else begin
                r_pc        <= w_pc4;
                r_ifid_inst <= r_imem[w_iidx];
                r_ifid_pc4  <= w_pc4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_ex_imm    <= '0;
            r_ex_pc4    <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_dst    <= '0;
            r_ex_aop    <= '0;
            r_ex_imm_en <= 1'b0;
            r_ex_wr     <= 1'b0;
            r_ex_mrd    <= 1'b0;
            r_ex_mwr    <= 1'b0;
            r_ex_link   <= 1'b0;
            r_ex_halt   <= 1'b0;
        end else begin
            r_ex_a      <= w_rs_v;
            r_ex_b      <= w_rt_v;
            r_ex_imm    <= w_imm;
            r_ex_pc4    <= r_ifid_pc4;
            r_ex_rs     <= w_rs;
            r_ex_rt     <= w_rt;
            r_ex_dst    <= w_dst;
            r_ex_aop    <= w_aop;
            r_ex_imm_en <= w_addi || w_lw || w_sw;
            r_ex_wr     <= w_wr && !w_stall;
            r_ex_mrd    <= w_lw && !w_stall;
            r_ex_mwr    <= w_sw && !w_stall;
            r_ex_link   <= (w_jal || w_jalr) && !w_stall;
            r_ex_halt   <= w_hlt && !w_stall;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_res  <= '0;
            r_mem_sd   <= '0;
            r_mem_dst  <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_mrd  <= 1'b0;
            r_mem_mwr  <= 1'b0;
            r_mem_halt <= 1'b0;
            r_wb_data  <= '0;
            r_wb_dst   <= '0;
            r_wb_wr    <= 1'b0;
            r_wb_halt  <= 1'b0;
        end else begin
            r_mem_res  <= w_ex_res;
            r_mem_sd   <= w_fb;
            r_mem_dst  <= r_ex_dst;
            r_mem_wr   <= r_ex_wr;
            r_mem_mrd  <= r_ex_mrd;
            r_mem_mwr  <= r_ex_mwr;
            r_mem_halt <= r_ex_halt;
            r_wb_data  <= r_mem_mrd ? w_ld : r_mem_res;
            r_wb_dst   <= r_mem_dst;
            r_wb_wr    <= r_mem_wr;
            r_wb_halt  <= r_mem_halt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 32; k++) r_rf[k] <= '0;
            r_halt <= 1'b0;
        end else begin
            if (r_wb_wr) r_rf[r_wb_dst] <= r_wb_data;
            r_halt <= r_halt | r_wb_halt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DMEM_WORDS; k++) r_dmem[k] <= '0;
        end else if (r_mem_mwr) begin
            r_dmem[w_didx] <= r_mem_sd;
        end
    end
endmodule

// File: tb/tb_mips_pipeline.sv
// tb_mips_pipeline: directed programs with hand-derived results, plus random programs
// checked against an instruction-at-a-time architectural model.
module tb_mips_pipeline;
    localparam int IW = 256;
    localparam int DW = 256;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] result;
    logic        halt;
    int          total = 0;
    int          bad = 0;
    int          ncyc;
    logic        got;
    logic [31:0] prog [IW];
    logic [31:0] res_log [512];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [DW];
    logic        m_halt;
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    mips_pipeline #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clk(clk), .reset(reset), .result(result), .halt(halt));

    always #5 clk = ~clk;

    function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic clear_prog();
        for (int k = 0; k < IW; k++) prog[k] = 32'h0;
    endtask

    task automatic run(input int maxc, input bit ld);
        reset = 1'b0;
        @(negedge clk);
        if (ld) for (int k = 0; k < IW; k++) dut.r_imem[k] = prog[k];
        @(negedge clk);
        reset = 1'b1;
        ncyc = 0;
        got = 1'b0;
        while (ncyc < maxc && !got) begin
            @(posedge clk);
            #1;
            ncyc++;
            if (ncyc < 512) res_log[ncyc] = result;
            got = halt;
        end
        chk("halt_reached", 32'(got), 32'd1);
    endtask

    task automatic mwr(input logic [4:0] d, input logic [31:0] v);
        if (d != 5'd0) m_reg[d] = v;
    endtask

    task automatic model();
        logic [31:0] pc, ins, a, b, sx, npc, addr;
        for (int k = 0; k < 32; k++) m_reg[k] = 32'h0;
        for (int k = 0; k < DW; k++) m_mem[k] = 32'h0;
        m_halt = 1'b0;
        pc = 32'h0;
        for (int s = 0; s < 4000 && !m_halt; s++) begin
            ins  = prog[int'((pc >> 2) % IW)];
            a    = m_reg[ins[25:21]];
            b    = m_reg[ins[20:16]];
            sx   = {{16{ins[15]}}, ins[15:0]};
            npc  = pc + 32'd4;
            addr = a + sx;
            case (ins[31:26])
                6'h00: case (ins[5:0])
                    6'h20: mwr(ins[15:11], a + b);
                    6'h22: mwr(ins[15:11], a - b);
                    6'h24: mwr(ins[15:11], a & b);
                    6'h25: mwr(ins[15:11], a | b);
                    6'h2A: mwr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    6'h08: npc = a;
                    6'h09: begin mwr(ins[15:11], pc + 32'd4); npc = a; end
                    default: ;
                endcase
                6'h08: mwr(ins[20:16], addr);
                6'h23: mwr(ins[20:16], m_mem[int'((addr >> 2) % DW)]);
                6'h2B: m_mem[int'((addr >> 2) % DW)] = b;
                6'h04: if (a == b) npc = pc + 32'd4 + (sx << 2);
                6'h05: if (a != b) npc = pc + 32'd4 + (sx << 2);
                6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
                6'h03: begin mwr(5'd31, pc + 32'd4); npc = {npc[31:28], ins[25:0], 2'b00}; end
                6'h3F: m_halt = 1'b1;
                default: ;
            endcase
            pc = npc;
        end
    endtask

    task automatic gen(input int n);
        clear_prog();
        for (int k = 0; k < n; k++) begin
            int t;
            logic [4:0] s, u, d;
            t = $urandom_range(0, 8);
            s = 5'($urandom_range(0, 7));
            u = 5'($urandom_range(0, 7));
            d = 5'($urandom_range(1, 7));
            if (t < 5) prog[k] = f_r(s, u, d, fns[t]);
            else if (t == 5) prog[k] = f_i(6'h08, s, d, 16'($urandom));
            else if (t == 6) prog[k] = f_i(6'h23, 5'd0, d, 16'(4 * $urandom_range(0, 15)));
            else if (t == 7) prog[k] = f_i(6'h2B, 5'd0, u, 16'(4 * $urandom_range(0, 15)));
            else prog[k] = f_i($urandom_range(0, 1) ? 6'h04 : 6'h05, s, u, 16'($urandom_range(0, 2)));
        end
        for (int k = n; k < n + 4; k++) prog[k] = HALT;
    endtask

    initial begin
        #12;
        chk("rst_result", result, 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_pc", dut.r_pc, 32'd0);

        clear_prog();
        prog[0] = f_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1] = f_i(6'h08, 5'd0, 5'd2, 16'd100);
        prog[2] = f_i(6'h08, 5'd0, 5'd16, 16'd24);
        prog[3] = f_r(5'd16, 5'd0, 5'd0, 6'h08);
        prog[4] = f_i(6'h08, 5'd0, 5'd3, 16'd3);
        prog[5] = f_i(6'h08, 5'd0, 5'd4, 16'd4);
        prog[6] = f_i(6'h08, 5'd2, 5'd5, 16'd53);
        prog[7] = f_i(6'h08, 5'd1, 5'd6, 16'd1);
        prog[8] = HALT;
        run(100, 1'b1);
        chk("jr_r5", dut.r_rf[5], 32'd153);
        chk("jr_r6", dut.r_rf[6], 32'd6);
        chk("jr_r3", dut.r_rf[3], 32'd0);
        chk("jr_r4", dut.r_rf[4], 32'd0);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) @(posedge clk);
        #3;
        chk("mid_r1_pre", dut.r_rf[1], 32'd5);
        reset = 1'b0;
        #1;
        chk("mid_pc", dut.r_pc, 32'd0);
        chk("mid_r1", dut.r_rf[1], 32'd0);
        chk("mid_result", result, 32'd0);

        clear_prog();
        prog[0]  = f_i(6'h08, 5'd0, 5'd7, 16'd64);
        prog[1]  = f_r(5'd7, 5'd0, 5'd31, 6'h09);
        prog[2]  = f_i(6'h08, 5'd0, 5'd8, 16'd8);
        prog[3]  = f_i(6'h08, 5'd0, 5'd9, 16'd9);
        prog[4]  = f_i(6'h08, 5'd0, 5'd10, 16'd10);
        prog[16] = f_i(6'h08, 5'd0, 5'd11, 16'd11);
        prog[17] = HALT;
        run(100, 1'b1);
        chk("jalr_r11", dut.r_rf[11], 32'd11);
        chk("jalr_r8", dut.r_rf[8], 32'd0);
        chk("jalr_r9", dut.r_rf[9], 32'd0);
        chk("jalr_r10", dut.r_rf[10], 32'd0);
        chk("jalr_r31", dut.r_rf[31], 32'd8);

        clear_prog();
        prog[0] = f_i(6'h08, 5'd0, 5'd1, 16'd7);
        prog[1] = f_i(6'h2B, 5'd0, 5'd1, 16'd4);
        prog[2] = f_i(6'h23, 5'd0, 5'd2, 16'd4);
        prog[3] = f_r(5'd2, 5'd2, 5'd3, 6'h20);
        prog[4] = HALT;
        run(100, 1'b1);
        chk("lu_r3", dut.r_rf[3], 32'd14);
        chk("lu_mem1", dut.r_dmem[1], 32'd7);
        chk("lu_halt_cycle", 32'(ncyc), 32'd9);
        chk("lu_result_add", res_log[8], 32'd14);
        chk("lu_result_halt", res_log[9], 32'd0);

        clear_prog();
        prog[0] = f_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = f_i(6'h04, 5'd1, 5'd1, 16'd1);
        prog[2] = f_i(6'h08, 5'd0, 5'd2, 16'd9);
        prog[3] = f_i(6'h08, 5'd0, 5'd3, 16'd3);
        prog[4] = HALT;
        run(100, 1'b1);
        chk("beq_r2", dut.r_rf[2], 32'd0);
        chk("beq_r3", dut.r_rf[3], 32'd3);
        prog[1] = f_i(6'h05, 5'd1, 5'd1, 16'd1);
        run(100, 1'b1);
        chk("bne_r2", dut.r_rf[2], 32'd9);
        chk("bne_r3", dut.r_rf[3], 32'd3);

        clear_prog();
        prog[0]  = f_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1]  = f_i(6'h08, 5'd0, 5'd2, 16'd2);
        prog[2]  = {6'h03, 26'd10};
        prog[3]  = f_i(6'h08, 5'd0, 5'd20, 16'd20);
        prog[10] = HALT;
        run(100, 1'b1);
        chk("jal_r31", dut.r_rf[31], 32'd12);
        chk("jal_r20", dut.r_rf[20], 32'd0);
        chk("jal_halt", 32'(halt), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_after_halt", 32'(halt), 32'd0);
        chk("rst_r31", dut.r_rf[31], 32'd0);
        chk("rst_pc2", dut.r_pc, 32'd0);
        run(100, 1'b0);
        chk("imem_kept_r31", dut.r_rf[31], 32'd12);

        for (int p = 0; p < 8; p++) begin
            gen(24);
            model();
            run(300, 1'b1);
            for (int k = 0; k < 32; k++)
                chk($sformatf("rnd%0d_r%0d", p, k), dut.r_rf[k], m_reg[k]);
            for (int k = 0; k < 16; k++)
                chk($sformatf("rnd%0d_m%0d", p, k), dut.r_dmem[k], m_mem[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
